// File: rtl/kbd_cursor_ctrl.sv
// Keyboard-driven cursor controller: key press edges become cursor steps, with auto-repeat after a hold delay.
// Build option: define CURSOR_WRAP_EN to make steps wrap at the display edges instead of saturating.
module kbd_cursor_ctrl #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int CURSOR_SIZE   = 16,
    parameter int STEP          = 4,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ps2OutCode,
    output logic [9:0] cursorX,
    output logic [9:0] cursorY,
    output logic [2:0] cursorCol,
    output logic       moved,
    output logic [1:0] o_dbg_state
);

    localparam logic [9:0] XMAX = 10'(H_ACTIVE - CURSOR_SIZE);
    localparam logic [9:0] YMAX = 10'(V_ACTIVE - CURSOR_SIZE);
    localparam logic [9:0] XC   = 10'((H_ACTIVE - CURSOR_SIZE) / 2);
    localparam logic [9:0] YC   = 10'((V_ACTIVE - CURSOR_SIZE) / 2);

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] XMAX_S = $signed({1'b0, XMAX});
    localparam logic signed [10:0] YMAX_S = $signed({1'b0, YMAX});

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] K_NONE  = 4'd0;
    localparam logic [3:0] K_UP    = 4'd1;
    localparam logic [3:0] K_DOWN  = 4'd2;
    localparam logic [3:0] K_LEFT  = 4'd3;
    localparam logic [3:0] K_RIGHT = 4'd4;
    localparam logic [3:0] K_HOME  = 4'd5;
    localparam logic [3:0] K_COL   = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      r_code;
    logic [3:0]      r_active;
    logic [3:0]      w_active_nxt;
    logic [3:0]      w_in_code;
    logic            w_act;

    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [2:0]      r_col;
    logic            r_moved;
    logic [9:0]      w_x_nxt;
    logic [9:0]      w_y_nxt;
    logic [2:0]      w_col_nxt;
    logic            w_moved_nxt;

    logic signed [10:0] w_x_dec;
    logic signed [10:0] w_x_inc;
    logic signed [10:0] w_y_dec;
    logic signed [10:0] w_y_inc;
    logic [9:0]      w_x_left;
    logic [9:0]      w_x_right;
    logic [9:0]      w_y_up;
    logic [9:0]      w_y_down;

    // Codes 7..F carry no action and are folded into "no key" before registering.
    assign w_in_code = (ps2OutCode > K_COL) ? K_NONE : ps2OutCode;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_code <= K_NONE;
        end else begin
            r_code <= w_in_code;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_active <= K_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
        end
    end

    // A release always returns to IDLE; a code differing from the held one counts as a fresh press.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_act        = 1'b0;
        if (r_code == K_NONE) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_active_nxt = K_NONE;
        end else if ((r_state == S_IDLE) || (r_code != r_active)) begin
            w_act        = 1'b1;
            w_active_nxt = r_code;
            w_cnt_nxt    = '0;
            w_state_nxt  = (r_code >= K_HOME) ? S_HOLD : S_DELAY;
        end else begin
            case (r_state)
                S_DELAY: begin
                    if (r_cnt == CW'(REPEAT_DELAY - 1)) begin
                        w_act       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (r_cnt == CW'(REPEAT_PERIOD - 1)) begin
                        w_act     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign w_x_dec = $signed({1'b0, r_x}) - STEP_S;
    assign w_x_inc = $signed({1'b0, r_x}) + STEP_S;
    assign w_y_dec = $signed({1'b0, r_y}) - STEP_S;
    assign w_y_inc = $signed({1'b0, r_y}) + STEP_S;

`ifdef CURSOR_WRAP_EN
    assign w_x_left  = w_x_dec[10]       ? XMAX  : w_x_dec[9:0];
    assign w_x_right = (w_x_inc > XMAX_S) ? 10'd0 : w_x_inc[9:0];
    assign w_y_up    = w_y_dec[10]       ? YMAX  : w_y_dec[9:0];
    assign w_y_down  = (w_y_inc > YMAX_S) ? 10'd0 : w_y_inc[9:0];
`else
    assign w_x_left  = w_x_dec[10]       ? 10'd0 : w_x_dec[9:0];
    assign w_x_right = (w_x_inc > XMAX_S) ? XMAX  : w_x_inc[9:0];
    assign w_y_up    = w_y_dec[10]       ? 10'd0 : w_y_dec[9:0];
    assign w_y_down  = (w_y_inc > YMAX_S) ? YMAX  : w_y_inc[9:0];
`endif

    // A step that leaves the position unchanged (already clamped) is not reported as a move.
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_col_nxt   = r_col;
        w_moved_nxt = 1'b0;
        if (w_act) begin
            case (r_code)
                K_UP: begin
                    w_y_nxt     = w_y_up;
                    w_moved_nxt = (w_y_up != r_y);
                end
                K_DOWN: begin
                    w_y_nxt     = w_y_down;
                    w_moved_nxt = (w_y_down != r_y);
                end
                K_LEFT: begin
                    w_x_nxt     = w_x_left;
                    w_moved_nxt = (w_x_left != r_x);
                end
                K_RIGHT: begin
                    w_x_nxt     = w_x_right;
                    w_moved_nxt = (w_x_right != r_x);
                end
                K_HOME: begin
                    w_x_nxt     = XC;
                    w_y_nxt     = YC;
                    w_moved_nxt = 1'b1;
                end
                K_COL: begin
                    w_col_nxt   = r_col + 3'd1;
                    w_moved_nxt = 1'b1;
                end
                default: begin
                    w_moved_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x     <= XC;
            r_y     <= YC;
            r_col   <= 3'b111;
            r_moved <= 1'b0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_col   <= w_col_nxt;
            r_moved <= w_moved_nxt;
        end
    end

    assign cursorX     = r_x;
    assign cursorY     = r_y;
    assign cursorCol   = r_col;
    assign moved       = r_moved;
    assign o_dbg_state = r_state;

endmodule
